// File: rtl/jpeg_pkg.sv
// Shared JPEG encoder constants: component count, index encodings, default DC width.
package jpeg_pkg;

  localparam int unsigned NUM_COMP = 3;
  localparam int unsigned DC_WIDTH = 11;
  localparam int unsigned COMP_W   = 2;

  typedef enum logic [COMP_W-1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_e;

  // True when a component index addresses an existing predictor
  function automatic logic comp_legal(input logic [COMP_W-1:0] comp, input int unsigned num);
    return 32'(comp) < num;
  endfunction

endpackage

// File: rtl/dc_predictor_bank.sv
// Per-component DC predictor storage with read mux, update and restart clear.
// Optional restart port enabled by DC_DIFF_RESTART_EN.
module dc_predictor_bank
  import jpeg_pkg::*;
#(
  parameter int unsigned WIDTH    = jpeg_pkg::DC_WIDTH,
  parameter int unsigned NUM_COMP = jpeg_pkg::NUM_COMP
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef DC_DIFF_RESTART_EN
  input  logic                    restart,
`endif
  input  logic [COMP_W-1:0]       rd_comp,
  output logic signed [WIDTH-1:0] rd_pred_c,
  input  logic                    wr_en,
  input  logic [COMP_W-1:0]       wr_comp,
  input  logic signed [WIDTH-1:0] wr_data
);

  logic signed [WIDTH-1:0] pred [NUM_COMP];
  logic                    restart_c;

`ifdef DC_DIFF_RESTART_EN
  assign restart_c = restart;
`else
  assign restart_c = 1'b0;
`endif

  // A restart makes every predictor read as zero in the same cycle
  always_comb begin
    rd_pred_c = '0;
    if (!restart_c) begin
      for (int i = 0; i < int'(NUM_COMP); i++) begin
        if (rd_comp == COMP_W'(i)) rd_pred_c = pred[i];
      end
    end
  end

  // Restart clears all, then the accepted write (if any) takes precedence
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_COMP); i++) pred[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_COMP); i++) begin
        if (restart_c) pred[i] <= '0;
        if (wr_en && (wr_comp == COMP_W'(i))) pred[i] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/dc_diff_encoder.sv
// JPEG DC differential encoder: out_diff = in_dc - previous DC of the same component.
// Optional restart-interval clear enabled by DC_DIFF_RESTART_EN.
module dc_diff_encoder
  import jpeg_pkg::*;
#(
  parameter int unsigned WIDTH    = jpeg_pkg::DC_WIDTH,
  parameter int unsigned NUM_COMP = jpeg_pkg::NUM_COMP
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef DC_DIFF_RESTART_EN
  input  logic                    restart,
`endif
  input  logic signed [WIDTH-1:0] in_dc,
  input  logic [COMP_W-1:0]       in_comp,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH:0]   out_diff,
  output logic [COMP_W-1:0]       out_comp,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err
);

  logic                    accept_c;
  logic                    legal_c;
  logic signed [WIDTH-1:0] pred_c;
  logic signed [WIDTH:0]   diff_c;

  assign in_ready = !out_valid || out_ready;
  assign accept_c = in_valid && in_ready;
  assign legal_c  = comp_legal(in_comp, NUM_COMP);
  assign diff_c   = {in_dc[WIDTH-1], in_dc} - {pred_c[WIDTH-1], pred_c};

  dc_predictor_bank #(
    .WIDTH    (WIDTH),
    .NUM_COMP (NUM_COMP)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
`ifdef DC_DIFF_RESTART_EN
    .restart   (restart),
`endif
    .rd_comp   (in_comp),
    .rd_pred_c (pred_c),
    .wr_en     (accept_c && legal_c),
    .wr_comp   (in_comp),
    .wr_data   (in_dc)
  );

  // Output register; illegal inputs are consumed without producing output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_diff  <= '0;
      out_comp  <= '0;
      err       <= 1'b0;
    end else begin
      if (accept_c && legal_c) begin
        out_valid <= 1'b1;
        out_diff  <= diff_c;
        out_comp  <= in_comp;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept_c && !legal_c) err <= 1'b1;
    end
  end

endmodule
